// File: rtl/prescaled_mode_counter_pkg.sv
// Shared encodings for the prescaled mode counter: count modes and direction values.
package counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_BOUNCE  = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/prescaled_mode_counter_tick_prescaler.sv
// Free-running N-bit enable prescaler; step is a combinational strobe on the wrap cycle.
module tick_prescaler #(
  parameter int N = 20
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic restart,
  output logic step
);

  // N=0 degenerates to a 1-bit counter pinned at zero, so step follows en.
  localparam int           PW   = (N > 0) ? N : 1;
  localparam logic [PW-1:0] TERM = (N > 0) ? {PW{1'b1}} : {PW{1'b0}};
  localparam logic [PW-1:0] ONE  = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0] cnt_r;

  // Prescaler count: restarts on clr/load, advances only while enabled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r <= {PW{1'b0}};
    end else if (restart) begin
      cnt_r <= {PW{1'b0}};
    end else if (en) begin
      if (cnt_r == TERM) begin
        cnt_r <= {PW{1'b0}};
      end else begin
        cnt_r <= cnt_r + ONE;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign step = en & (cnt_r == TERM);

endmodule

// File: rtl/prescaled_mode_counter.sv
// Prescaled up/down counter with wrap, saturate, bounce and one-shot modes,
// synchronous clear/load and registered tick, terminal-count and done outputs.
module prescaled_mode_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int N     = 20,
  parameter int MAXV  = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] data,
  output logic             tick,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAXV_L = WIDTH'(MAXV);
  localparam logic [WIDTH-1:0] ZERO_L = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_L  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] data_r;
  logic             tick_r;
  logic             tc_r;
  logic             done_r;
  logic             bdir_r;

  logic             step_s;
  logic             edir_s;
  logic [WIDTH-1:0] term_s;
  logic [WIDTH-1:0] inc_s;
  logic [WIDTH-1:0] dec_s;
  logic [WIDTH-1:0] nxt_data_s;
  logic             nxt_bdir_s;
  logic             nxt_done_s;
  logic             nxt_tc_s;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    if (v > MAXV_L) begin
      return MAXV_L;
    end else begin
      return v;
    end
  endfunction

  tick_prescaler #(.N(N)) u_prescaler (
    .clk     (clk),
    .rstn    (rstn),
    .en      (en),
    .restart (clr | load),
    .step    (step_s)
  );

  // Next-state computation for one step; wrap points are explicit compares against MAXV.
  always_comb begin
    edir_s     = (mode == MODE_BOUNCE) ? bdir_r : dir;
    term_s     = (edir_s == DIR_UP) ? MAXV_L : ZERO_L;
    inc_s      = (data_r >= MAXV_L) ? ZERO_L : data_r + ONE_L;
    dec_s      = (data_r == ZERO_L) ? MAXV_L : data_r - ONE_L;
    nxt_data_s = data_r;
    nxt_bdir_s = edir_s;
    nxt_done_s = done_r;
    nxt_tc_s   = 1'b0;
    if (step_s) begin
      case (mode)
        MODE_WRAP: begin
          nxt_data_s = (edir_s == DIR_UP) ? inc_s : dec_s;
          nxt_tc_s   = (nxt_data_s == term_s);
        end
        MODE_SAT: begin
          if (data_r == term_s) begin
            nxt_data_s = data_r;
          end else begin
            nxt_data_s = (edir_s == DIR_UP) ? inc_s : dec_s;
          end
          nxt_tc_s = (data_r != term_s) && (nxt_data_s == term_s);
        end
        MODE_BOUNCE: begin
          // Turn around at an endpoint so the endpoint value is never repeated.
          if (edir_s == DIR_UP) begin
            nxt_data_s = (data_r >= MAXV_L) ? dec_s : inc_s;
          end else begin
            nxt_data_s = (data_r == ZERO_L) ? inc_s : dec_s;
          end
          nxt_tc_s = (nxt_data_s == MAXV_L) || (nxt_data_s == ZERO_L);
          if (nxt_data_s == MAXV_L) begin
            nxt_bdir_s = DIR_DOWN;
          end else if (nxt_data_s == ZERO_L) begin
            nxt_bdir_s = DIR_UP;
          end else if (nxt_data_s < data_r) begin
            nxt_bdir_s = DIR_DOWN;
          end else begin
            nxt_bdir_s = DIR_UP;
          end
        end
        MODE_ONESHOT: begin
          if (done_r) begin
            nxt_data_s = data_r;
          end else if (data_r == term_s) begin
            nxt_done_s = 1'b1;
          end else begin
            nxt_data_s = (edir_s == DIR_UP) ? inc_s : dec_s;
            nxt_tc_s   = (nxt_data_s == term_s);
            nxt_done_s = (nxt_data_s == term_s);
          end
        end
        default: begin
          nxt_data_s = data_r;
        end
      endcase
    end else begin
      nxt_data_s = data_r;
    end
  end

  // State and output registers; clr beats load beats step.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_r <= ZERO_L;
      tick_r <= 1'b0;
      tc_r   <= 1'b0;
      done_r <= 1'b0;
      bdir_r <= DIR_UP;
    end else if (clr) begin
      data_r <= ZERO_L;
      tick_r <= 1'b0;
      tc_r   <= 1'b0;
      done_r <= 1'b0;
      bdir_r <= dir;
    end else if (load) begin
      data_r <= clamp_load(load_val);
      tick_r <= 1'b0;
      tc_r   <= 1'b0;
      done_r <= 1'b0;
      bdir_r <= dir;
    end else begin
      data_r <= nxt_data_s;
      tick_r <= step_s;
      tc_r   <= nxt_tc_s;
      done_r <= nxt_done_s;
      bdir_r <= nxt_bdir_s;
    end
  end

  assign data = data_r;
  assign tick = tick_r;
  assign tc   = tc_r;
  assign done = done_r;

endmodule
